// File: rtl/ppm_pkg.sv
// Shared order encodings, slot-length defaults and FSM state type for the PPM
// transmit scheduler.
package ppm_pkg;

  localparam logic [1:0] ORD_IDLE = 2'b00;
  localparam logic [1:0] ORD_SOF  = 2'b01;
  localparam logic [1:0] ORD_DATA = 2'b10;
  localparam logic [1:0] ORD_EOF  = 2'b11;

  localparam int SLOT_CYCLES_DEF = 128;
  localparam int EOF_CYCLES_DEF  = 64;

  // State codes equal the order codes so the state register drives order directly.
  typedef enum logic [1:0] {
    ST_IDLE = ORD_IDLE,
    ST_SOF  = ORD_SOF,
    ST_DATA = ORD_DATA,
    ST_EOF  = ORD_EOF
  } state_t;

endpackage

// File: rtl/ppm_rr_arbiter.sv
// Round-robin one-hot pick over req_valid, combinational; pointer moves past the
// winner on the cycle grant_stb is high.
module ppm_rr_arbiter
  import ppm_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             grant_stb,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   cand;

  always_comb begin
    any      = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(off);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!any && req_valid[cand[IW-1:0]]) begin
        any      = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
    pick = any ? (N_REQ'(1) << pick_idx) : '0;
  end

  assign ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_stb) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ppm_frame_scheduler.sv
// Arbitrates N_REQ byte streams onto one PPM generator as SOF / 4 symbols per byte / EOF;
// SOF starts the cycle after acceptance, req_ready is combinational and only at byte boundaries.
module ppm_frame_scheduler
  import ppm_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int EOF_CYCLES  = EOF_CYCLES_DEF,
  parameter int MAX_BYTES   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [1:0]         order,
  output logic [9:0]         clk_count,
  output logic [1:0]         bit_count,
  output logic [7:0]         tx_byte,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               underrun
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [9:0]    SLOT_LAST = 10'(SLOT_CYCLES - 1);
  localparam logic [9:0]    EOF_LAST  = 10'(EOF_CYCLES - 1);
  localparam logic [BW-1:0] BYTES_MAX = BW'(MAX_BYTES);

  state_t           state_q;
  logic [9:0]       clk_cnt_q;
  logic [1:0]       bit_cnt_q;
  logic [7:0]       tx_byte_q;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    gidx_q;
  logic             last_q;
  logic [BW-1:0]    byte_cnt_q;
  logic             underrun_q;

  logic [N_REQ-1:0] arb_pick;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             idle_acc, slot_end, byte_end, more_ok, data_acc;
  logic [IW-1:0]    lane_idx;
  logic [7:0]       lane_dat;

  assign idle_acc = (state_q == ST_IDLE) && arb_any;
  assign slot_end = (clk_cnt_q == SLOT_LAST);
  assign byte_end = (state_q == ST_DATA) && (bit_cnt_q == 2'd3) && slot_end;
  // more_ok: the frame may take another byte from its owner at this boundary.
  assign more_ok  = byte_end && !last_q && (byte_cnt_q != BYTES_MAX);
  assign data_acc = more_ok && req_valid[gidx_q];

  assign lane_idx = (state_q == ST_IDLE) ? arb_idx : gidx_q;
  assign lane_dat = req_data[{lane_idx, 3'b000} +: 8];

  ppm_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant_stb (idle_acc),
    .pick      (arb_pick),
    .pick_idx  (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE) req_ready = arb_pick;
    else if (more_ok)       req_ready = grant_q & req_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_byte_q  <= '0;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= 1'b0;
      byte_cnt_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (idle_acc) begin
            tx_byte_q  <= lane_dat;
            last_q     <= req_last[arb_idx];
            grant_q    <= arb_pick;
            gidx_q     <= arb_idx;
            byte_cnt_q <= BW'(1);
            clk_cnt_q  <= '0;
            state_q    <= ST_SOF;
          end
        end
        ST_SOF: begin
          if (slot_end) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 10'd1;
          end
        end
        ST_DATA: begin
          if (slot_end) begin
            clk_cnt_q <= '0;
            if (bit_cnt_q != 2'd3) begin
              bit_cnt_q <= bit_cnt_q + 2'd1;
            end else if (data_acc) begin
              tx_byte_q  <= lane_dat;
              last_q     <= req_last[gidx_q];
              byte_cnt_q <= byte_cnt_q + BW'(1);
              bit_cnt_q  <= '0;
            end else begin
              state_q    <= ST_EOF;
              underrun_q <= more_ok;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 10'd1;
          end
        end
        ST_EOF: begin
          if (clk_cnt_q == EOF_LAST) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
          end else begin
            clk_cnt_q <= clk_cnt_q + 10'd1;
          end
        end
      endcase
    end
  end

  assign order     = state_q;
  assign clk_count = clk_cnt_q;
  assign bit_count = bit_cnt_q;
  assign tx_byte   = tx_byte_q;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// Bench for ppm_frame_scheduler: frame-time reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ppm_frame_scheduler;

  localparam int N  = 2;
  localparam int S  = 128;
  localparam int E  = 64;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [1:0]     order;
  logic [9:0]     clk_count;
  logic [1:0]     bit_count;
  logic [7:0]     tx_byte;
  logic [N-1:0]   grant;
  logic           busy;
  logic           underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_under = 0;

  // Reference model state: frame time since SOF start, bytes taken, EOF time.
  int m_known = 0, m_act = 0, m_t = 0, m_n = 0, m_own = 0, m_last = 0, m_eof = -1, m_ptr = 0;
  int m_under = 0;
  int m_byte = 0;
  int win, exp_rdy, e_ord, e_clk, e_bit;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ppm_frame_scheduler #(
    .N_REQ(N), .SLOT_CYCLES(S), .EOF_CYCLES(E), .MAX_BYTES(MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .order     (order),
    .clk_count (clk_count),
    .bit_count (bit_count),
    .tx_byte   (tx_byte),
    .grant     (grant),
    .busy      (busy),
    .underrun  (underrun)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte on lane i and wait (bounded) for the transfer; returns the
  // cycle in which ready was seen, or -1. Leaves the bench in the cycle after.
  task automatic offer(input int i, input logic [7:0] d, input bit l, input int maxw,
                       output int acc);
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
    req_valid[i]       = 1'b1;
    acc = -1;
    for (int w = 0; w < maxw; w++) begin
      #1;
      if (req_ready[i]) begin
        acc = cyc;
        break;
      end
      @(posedge clk);
    end
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL offer_timeout: lane %0d never ready, expected ready within %0d cycles", i, maxw);
    end else begin
      step();
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int maxw, output int t);
    t = -1;
    for (int w = 0; w < maxw; w++) begin
      if (!busy) begin
        t = cyc;
        break;
      end
      step();
    end
    if (t < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy still 1, expected 0 within %0d cycles", maxw);
    end
  endtask

  // Every-cycle compare against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      win = -1;
      exp_rdy = 0;
      if (m_act == 0) begin
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        if (win >= 0) exp_rdy = 1 << win;
      end else if (m_eof < 0 && m_t == S + 4*S*m_n - 1 && m_last == 0 && m_n < MB
                   && req_valid[m_own]) begin
        exp_rdy = 1 << m_own;
      end
      if (m_known != 0) begin
        if (m_act == 0)    begin e_ord = 0; e_clk = 0;     e_bit = 0;  end
        else if (m_eof >= 0) begin e_ord = 3; e_clk = m_eof; e_bit = -1; end
        else if (m_t < S)  begin e_ord = 1; e_clk = m_t;   e_bit = 0;  end
        else begin
          e_ord = 2;
          e_clk = (m_t - S) % S;
          e_bit = ((m_t - S) / S) % 4;
        end
        chk("order", int'(order), e_ord);
        chk("clk_count", int'(clk_count), e_clk);
        if (e_bit >= 0) chk("bit_count", int'(bit_count), e_bit);
        chk("tx_byte", int'(tx_byte), m_byte);
        chk("grant", int'(grant), (m_act != 0) ? (1 << m_own) : 0);
        chk("busy", int'(busy), (m_act != 0) ? 1 : 0);
        chk("underrun", int'(underrun), m_under);
        chk("req_ready", int'(req_ready), exp_rdy);
      end
      if (underrun === 1'b1) n_under++;
      if (rst) begin
        m_known = 1; m_act = 0; m_ptr = 0; m_byte = 0; m_under = 0; m_eof = -1;
      end else if (m_known != 0) begin
        m_under = 0;
        if (m_act == 0) begin
          if (win >= 0) begin
            m_act = 1; m_t = 0; m_n = 1; m_eof = -1; m_own = win;
            m_last = int'(req_last[win]);
            m_byte = int'(req_data[8*win +: 8]);
            m_ptr = (win + 1) % N;
          end
        end else if (m_eof >= 0) begin
          if (m_eof == E - 1) m_act = 0;
          else m_eof++;
        end else if (m_t == S + 4*S*m_n - 1) begin
          if (m_last != 0 || m_n == MB) m_eof = 0;
          else if (req_valid[m_own]) begin
            m_n++;
            m_t++;
            m_last = int'(req_last[m_own]);
            m_byte = int'(req_data[8*m_own +: 8]);
          end else begin
            m_eof = 0;
            m_under = 1;
          end
        end else begin
          m_t++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int acc0, acc1, acc2, t_end, u0;
    int sym_exp[4];
    int rr_exp[3];
    sym_exp = '{0, 1, 3, 2};
    rr_exp  = '{1, 2, 1};
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    step(); step(); step();
    chk("rst_order", int'(order), 0);
    chk("rst_clk_count", int'(clk_count), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    step();

    // Single byte 0xB4 from req0: symbols 0,1,3,2, IDLE at 704.
    offer(0, 8'hB4, 1'b1, 10, acc0);
    chk("sof_order", int'(order), 1);
    chk("sof_clk_count", int'(clk_count), 0);
    for (int k = 0; k < 4; k++) begin
      repeat (S) step();
      chk("sym_order", int'(order), 2);
      chk("sym_bit_count", int'(bit_count), k);
      chk("sym_value", int'((tx_byte >> (2*k)) & 8'h03), sym_exp[k]);
    end
    repeat (S) step();
    chk("eof_order_at_640", int'(order), 3);
    repeat (E) step();
    chk("idle_order_at_704", int'(order), 0);
    step();

    // Three-byte frame from req1.
    u0 = n_under;
    offer(1, 8'h11, 1'b0, 10, acc0);
    offer(1, 8'h22, 1'b0, 1000, acc1);
    offer(1, 8'h33, 1'b1, 1000, acc2);
    chk("accept2_offset", acc1 - acc0, 640);
    chk("accept3_offset", acc2 - acc0, 1152);
    wait_idle(2000, t_end);
    chk("frame3_length", t_end - acc0 - 1, 1728);
    chk("frame3_underruns", n_under - u0, 0);

    // Contention: both valid, round-robin alternates 01/10/01.
    req_data = 16'hBEEF;
    req_last = 2'b11;
    req_valid = 2'b11;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 10; w++) begin
        #1;
        if (req_ready != '0) break;
        @(posedge clk);
      end
      chk("rr_ready", int'(req_ready), rr_exp[f]);
      step();
      chk("rr_grant", int'(grant), rr_exp[f]);
      if (f == 2) req_valid = '0;
      wait_idle(1000, t_end);
    end
    req_last = '0;

    // Underrun: one byte without last, then valid dropped.
    u0 = n_under;
    offer(0, 8'h5A, 1'b0, 10, acc0);
    repeat (4*S + S) step();
    chk("underrun_eof_order", int'(order), 3);
    chk("underrun_pulse", int'(underrun), 1);
    step();
    chk("underrun_one_cycle", int'(underrun), 0);
    wait_idle(1000, t_end);
    chk("underrun_frame_length", t_end - acc0 - 1, 704);
    chk("underrun_count", n_under - u0, 1);

    // MAX_BYTES without last closes normally after the 16th byte.
    u0 = n_under;
    offer(1, 8'h01, 1'b0, 10, acc0);
    for (int b = 2; b <= MB; b++) offer(1, 8'(b), 1'b0, 1000, acc1);
    req_valid[1] = 1'b1;
    wait_idle(9000, t_end);
    req_valid[1] = 1'b0;
    chk("max_frame_length", t_end - acc0 - 1, 192 + 512*MB);
    chk("max_underruns", n_under - u0, 0);
    step();

    // Reset mid-DATA after a req0 win; pointer must return to req0.
    offer(0, 8'h77, 1'b1, 10, acc0);
    repeat (300) step();
    chk("pre_rst_order", int'(order), 2);
    rst = 1'b1;
    step();
    chk("mid_rst_order", int'(order), 0);
    chk("mid_rst_clk_count", int'(clk_count), 0);
    chk("mid_rst_bit_count", int'(bit_count), 0);
    chk("mid_rst_tx_byte", int'(tx_byte), 0);
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    req_last = 2'b11;
    req_valid = 2'b11;
    #1;
    chk("rst_rr_ready", int'(req_ready), 1);
    step();
    chk("rst_rr_grant", int'(grant), 1);
    req_valid = '0;
    wait_idle(1000, t_end);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 15000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 199) == 0) req_valid[i] = ~req_valid[i];
        req_last[i] = ($urandom_range(0, 2) == 0);
      end
      req_data = 16'($urandom);
      rst = ($urandom_range(0, 4999) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    wait_idle(9000, t_end);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ppm_frame_scheduler.md
# ppm_frame_scheduler

Sequencer and arbiter for the PPM transmit path. It shares one PPM symbol generator between `N_REQ` byte-stream requesters and drives the generator's `order` / `clk_count` / `bit_count` controls. It frames each requester's burst as one SOF slot, 4 two-bit PPM symbols per byte, and one EOF slot. It sits between the serial-to-parallel front ends and the PPM symbol generator that produces `Dout`.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..8).
- `SLOT_CYCLES`, 128, clocks per SOF slot and per data symbol (≤1024).
- `EOF_CYCLES`, 64, clocks per EOF slot (≤ `SLOT_CYCLES`).
- `MAX_BYTES`, 16, maximum bytes per frame (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  N_REQ  requester i has a byte on its data lane.
- `req_data`  in  8*N_REQ  byte lanes; lane i is `[8i+7:8i]`.
- `req_last`  in  N_REQ  the offered byte ends the frame.
- `req_ready`  out  N_REQ  combinational accept; a transfer happens on an edge where `req_valid[i] && req_ready[i]`.
- `order`  out  2  symbol type: 00 idle, 01 SOF, 10 DATA, 11 EOF.
- `clk_count`  out  10  cycle index within the current slot.
- `bit_count`  out  2  symbol index within the byte, 0..3; symbol k carries `tx_byte[2k+1:2k]`.
- `tx_byte`  out  8  byte being transmitted.
- `grant`  out  N_REQ  one-hot owner of the current frame.
- `busy`  out  1  high when `order != 00`.
- `underrun`  out  1  one-cycle pulse when a frame is aborted.

## Operation
States: IDLE, SOF, DATA, EOF.

**IDLE**
- Round-robin arbitration over `req_valid`. Priority starts at the requester after the last winner; after reset, requester 0 has top priority.
- The winner's `req_ready` is high combinationally. On the transfer edge:
  - `tx_byte` ← lane data.
  - `last_q` ← `req_last`.
  - `grant` ← winner.
  - `byte_cnt` ← 1.
  - Pointer advances past the winner.
  - State → SOF, `clk_count` ← 0.

**SOF**
- `clk_count` counts 0..`SLOT_CYCLES`-1.
- At the terminal count: → DATA, `bit_count` ← 0.

**DATA**
- `clk_count` wraps every `SLOT_CYCLES`; `bit_count` increments at each wrap.
- At `bit_count==3` and terminal count:
  - If `last_q` or `byte_cnt==MAX_BYTES`: → EOF.
  - Else, if the granted requester is valid: its `req_ready` is high and it transfers. `tx_byte`, `last_q` update, `byte_cnt`+1, `bit_count` ← 0, stay in DATA.
  - Else: → EOF with `underrun` pulsed on the same edge.
- Reaching `MAX_BYTES` without `last` is a normal frame close, not an underrun.

**EOF**
- `clk_count` counts 0..`EOF_CYCLES`-1.
- At the terminal count: → IDLE. `grant` ← 0, `clk_count` ← 0, `bit_count` ← 0.

**General rules**
- `req_ready` is 0 at all other times, including for non-granted requesters during a frame.
- `req_valid` is sampled only at the acceptance points above. Drops between them are ignored.

## Timing
- Reset values (one edge after `rst` is sampled high): `order`=00, `clk_count`=0, `bit_count`=0, `tx_byte`=0, `grant`=0, `busy`=0, `underrun`=0, `req_ready`=0, RR pointer → requester 0.
- Reset mid-frame truncates the frame immediately. No EOF is sent.
- Accept-to-SOF latency: `order`=01 and `clk_count`=0 in the first cycle after the transfer edge.
- Frame length: `SLOT_CYCLES` + 4·`SLOT_CYCLES`·N + `EOF_CYCLES` cycles (for defaults, 192 + 512·N).
- IDLE lasts at least 1 cycle between frames, so there is no back-to-back SOF.
- Outputs `order`, `clk_count`, `bit_count`, `tx_byte`, `grant` are registered. `req_ready` is combinational from state and `req_valid`.
- `clk_count` is 10 bits unsigned. Terminal compares use `SLOT_CYCLES-1` and `EOF_CYCLES-1`, so the counter never overflows.
- Simultaneous requests are resolved by RR only. A requester winning while another is mid-frame is impossible, because arbitration happens only in IDLE.

## Structure
- Shared package `ppm_pkg`:
  - `order` encodings `ORD_IDLE`/`ORD_SOF`/`ORD_DATA`/`ORD_EOF`.
  - Default `SLOT_CYCLES`/`EOF_CYCLES`.
  - State enum type.
- Sub-module `ppm_rr_arbiter`: combinational one-hot round-robin pick from `req_valid` and the pointer, plus a pointer register updated on a grant strobe.
- Counters and the FSM live in the top module.

## Test plan
- Single requester, 1 byte: req0 offers 0xB4 with `last`=1 → `req_ready[0]` high 1 cycle. Then SOF for 128 cycles, DATA `bit_count` 0..3 carrying symbols 0,1,3,2, EOF for 64 cycles, IDLE at cycle 704.
- Multi-byte frame: req1 offers 0x11, 0x22, 0x33 (`last` on 0x33) → accepts at 0, 640, 1152. Total frame 1728 cycles, `underrun`=0.
- Contention: both requesters valid from reset → req0 framed first, then req1, then req0 again; `grant` alternates 01/10/01.
- Underrun: req0 sends 0x5A with `last`=0, then drops valid → EOF follows byte 1, `underrun` pulses once at cycle 640.
- Limits: 16 bytes with no `last` → EOF after the 16th byte, `underrun`=0. `rst` asserted mid-DATA → all outputs at reset values next cycle, RR pointer back to requester 0.
